// File: rtl/scoreboard_pkg.sv
// Shared constants and helpers for the two-player score keeper:
// BCD digit width, 7-segment glyph table, digit-select codes and scan order.
package scoreboard_pkg;

  localparam int BCD_W = 4;

  // Glyphs for digits 0..9, active-high, bit order gfedcba.
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One-hot digit selects, in display scan order.
  localparam logic [3:0] DIG_P1_TENS  = 4'b0001;
  localparam logic [3:0] DIG_P1_UNITS = 4'b0010;
  localparam logic [3:0] DIG_P2_TENS  = 4'b0100;
  localparam logic [3:0] DIG_P2_UNITS = 4'b1000;

  typedef enum logic [1:0] {
    SCAN_P1_TENS  = 2'd0,
    SCAN_P1_UNITS = 2'd1,
    SCAN_P2_TENS  = 2'd2,
    SCAN_P2_UNITS = 2'd3
  } scan_e;

  // Decimal constant to two-digit packed BCD {tens, units}.
  function automatic logic [2*BCD_W-1:0] to_bcd(input int value);
    return {BCD_W'(value / 10), BCD_W'(value % 10)};
  endfunction

  // Digit to glyph; non-decimal codes show nothing.
  function automatic logic [6:0] seg_encode(input logic [BCD_W-1:0] digit);
    if (digit < BCD_W'(10)) return SEG_TABLE[digit];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// One player's score: rising-edge detection on the up/down requests,
// saturating two-digit BCD up/down count and synchronous clear.
module bcd_score_counter
  import scoreboard_pkg::*;
#(
  parameter int MAX_SCORE = 99
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up,
  input  logic                 down,
  input  logic                 clear,
  output logic [2*BCD_W-1:0]   score
);

  localparam logic [2*BCD_W-1:0] MAX_BCD = to_bcd(MAX_SCORE);

  logic up_q;
  logic down_q;
  // Low until the first edge after reset release, so a request that is
  // already high at release only loads the history and is never counted.
  logic primed;

  logic up_evt;
  logic down_evt;
  logic [BCD_W-1:0] tens;
  logic [BCD_W-1:0] units;
  logic [2*BCD_W-1:0] score_inc;
  logic [2*BCD_W-1:0] score_dec;

  assign up_evt   = primed & up   & ~up_q;
  assign down_evt = primed & down & ~down_q;

  assign tens  = score[2*BCD_W-1:BCD_W];
  assign units = score[BCD_W-1:0];

  // BCD neighbours of the current score, with digit carry/borrow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    score_inc = score;
    score_dec = score;
    if (units == BCD_W'(9)) score_inc = {tens + BCD_W'(1), BCD_W'(0)};
    else                    score_inc = {tens, units + BCD_W'(1)};
    if (units == BCD_W'(0)) score_dec = {tens - BCD_W'(1), BCD_W'(9)};
    else                    score_dec = {tens, units - BCD_W'(1)};
  end

  // Request history and score register; clear wins over any event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      primed <= 1'b0;
      score  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      up_q   <= up;
      down_q <= down;
      primed <= 1'b1;
      if (clear) begin
        score <= '0;
      end else if (up_evt && !down_evt) begin
        if (score != MAX_BCD) score <= score_inc;
      end else if (down_evt && !up_evt) begin
        if (score != '0) score <= score_dec;
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Two-player score keeper: two BCD score counters plus a four-digit
// multiplexed 7-segment display scanned one digit per clock.
module score_keeper
  import scoreboard_pkg::*;
#(
  parameter int MAX_SCORE = 99
) (
  input  logic               clk_1khz,
  input  logic               rst_i,
  input  logic               p1_up_i,
  input  logic               p1_down_i,
  input  logic               p2_up_i,
  input  logic               p2_down_i,
  input  logic               clear_i,
  output logic [2*BCD_W-1:0] score_p1_o,
  output logic [2*BCD_W-1:0] score_p2_o,
  output logic [6:0]         seg_o,
  output logic [3:0]         dig_sel_o
);

  bcd_score_counter #(.MAX_SCORE(MAX_SCORE)) u_p1 (
    .clk   (clk_1khz),
    .rst_n (rst_i),
    .up    (p1_up_i),
    .down  (p1_down_i),
    .clear (clear_i),
    .score (score_p1_o)
  );

  bcd_score_counter #(.MAX_SCORE(MAX_SCORE)) u_p2 (
    .clk   (clk_1khz),
    .rst_n (rst_i),
    .up    (p2_up_i),
    .down  (p2_down_i),
    .clear (clear_i),
    .score (score_p2_o)
  );

  scan_e            scan_idx;
  scan_e            scan_next;
  logic [BCD_W-1:0] digit;
  logic             is_tens;
  logic [3:0]       sel_next;
  logic [6:0]       seg_next;

  assign scan_next = scan_e'(scan_idx + 2'd1);

  // Pick the digit and select for the slot the scan moves into, so the
  // registered outputs always match the scan index they are shown with.
  always_comb begin
    digit    = '0;
    is_tens  = 1'b0;
    sel_next = DIG_P1_TENS;
    case (scan_next)
      SCAN_P1_TENS: begin
        digit    = score_p1_o[2*BCD_W-1:BCD_W];
        is_tens  = 1'b1;
        sel_next = DIG_P1_TENS;
      end
      SCAN_P1_UNITS: begin
        digit    = score_p1_o[BCD_W-1:0];
        sel_next = DIG_P1_UNITS;
      end
      SCAN_P2_TENS: begin
        digit    = score_p2_o[2*BCD_W-1:BCD_W];
        is_tens  = 1'b1;
        sel_next = DIG_P2_TENS;
      end
      SCAN_P2_UNITS: begin
        digit    = score_p2_o[BCD_W-1:0];
        sel_next = DIG_P2_UNITS;
      end
      default: ;
    endcase
    // Leading zero suppression applies to tens digits only.
    seg_next = (is_tens && digit == '0) ? SEG_BLANK : seg_encode(digit);
  end

  // Scan index plus select and segment registers, all updated together.
  always_ff @(posedge clk_1khz or negedge rst_i) begin
    if (!rst_i) begin
      scan_idx  <= SCAN_P1_TENS;
      dig_sel_o <= DIG_P1_TENS;
      seg_o     <= SEG_BLANK;
    end else begin
      scan_idx  <= scan_next;
      dig_sel_o <= sel_next;
      seg_o     <= seg_next;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed test of score_keeper: edge detection, BCD saturation, same-edge
// conflicts, display scan, clear priority and mid-operation reset.
module tb_score_keeper;

  logic       clk_1khz = 1'b0;
  logic       rst_i = 1'b0;
  logic       p1_up_i = 1'b0;
  logic       p1_down_i = 1'b0;
  logic       p2_up_i = 1'b0;
  logic       p2_down_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [7:0] score_p1_o;
  logic [7:0] score_p2_o;
  logic [6:0] seg_o;
  logic [3:0] dig_sel_o;

  int n_checks = 0;
  int n_errors = 0;

  score_keeper #(.MAX_SCORE(99)) dut (
    .clk_1khz   (clk_1khz),
    .rst_i      (rst_i),
    .p1_up_i    (p1_up_i),
    .p1_down_i  (p1_down_i),
    .p2_up_i    (p2_up_i),
    .p2_down_i  (p2_down_i),
    .clear_i    (clear_i),
    .score_p1_o (score_p1_o),
    .score_p2_o (score_p2_o),
    .seg_o      (seg_o),
    .dig_sel_o  (dig_sel_o)
  );

  always #5 clk_1khz = ~clk_1khz;

  task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one request pattern for one cycle, then one idle cycle.
  task automatic apply(input logic u1, input logic d1, input logic u2, input logic d2, input logic clr);
    p1_up_i = u1; p1_down_i = d1; p2_up_i = u2; p2_down_i = d2; clear_i = clr;
    @(negedge clk_1khz);
    p1_up_i = 1'b0; p1_down_i = 1'b0; p2_up_i = 1'b0; p2_down_i = 1'b0; clear_i = 1'b0;
    @(negedge clk_1khz);
  endtask

  task automatic pulses(input int n, input logic u1, input logic d1, input logic u2, input logic d2);
    for (int i = 0; i < n; i++) apply(u1, d1, u2, d2, 1'b0);
  endtask

  initial begin
    logic found;
    logic [3:0] exp_sel [4];
    logic [6:0] exp_seg [4];
    exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_seg = '{7'h66, 7'h5B, 7'h00, 7'h07};

    // Reset values while reset is held.
    repeat (3) @(negedge clk_1khz);
    check("rst_p1", score_p1_o, 8'h00);
    check("rst_p2", score_p2_o, 8'h00);
    check("rst_sel", dig_sel_o, 4'b0001);
    check("rst_seg", seg_o, 7'h00);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_1khz);

    // Twelve single-cycle pulses on player 1.
    pulses(12, 1, 0, 0, 0);
    check("p1_twelve", score_p1_o, 8'h12);
    check("p2_untouched", score_p2_o, 8'h00);

    // Held level counts once.
    p1_up_i = 1'b1;
    repeat (50) @(negedge clk_1khz);
    p1_up_i = 1'b0;
    @(negedge clk_1khz);
    check("p1_held_once", score_p1_o, 8'h13);

    // BCD carry/borrow and saturation on player 2.
    pulses(9, 0, 0, 1, 0);
    check("p2_09", score_p2_o, 8'h09);
    pulses(1, 0, 0, 1, 0);
    check("p2_carry_10", score_p2_o, 8'h10);
    pulses(1, 0, 0, 0, 1);
    check("p2_borrow_09", score_p2_o, 8'h09);
    pulses(9, 0, 0, 0, 1);
    check("p2_down_00", score_p2_o, 8'h00);
    pulses(1, 0, 0, 0, 1);
    check("p2_floor_00", score_p2_o, 8'h00);
    pulses(99, 0, 0, 1, 0);
    check("p2_99", score_p2_o, 8'h99);
    pulses(1, 0, 0, 1, 0);
    check("p2_ceiling_99", score_p2_o, 8'h99);

    // Same-edge up+down on P1 cancels while P2 up still counts.
    apply(0, 0, 0, 0, 1);
    check("clear_p2", score_p2_o, 8'h00);
    pulses(5, 1, 0, 0, 0);
    check("p1_05", score_p1_o, 8'h05);
    apply(1, 1, 1, 0, 0);
    check("p1_conflict_05", score_p1_o, 8'h05);
    check("p2_same_edge_01", score_p2_o, 8'h01);

    // Display scan with scores 42 / 07.
    apply(0, 0, 0, 0, 1);
    pulses(7, 1, 0, 1, 0);
    pulses(35, 1, 0, 0, 0);
    check("p1_42", score_p1_o, 8'h42);
    check("p2_07", score_p2_o, 8'h07);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk_1khz);
      if (dig_sel_o == 4'b0001) found = 1'b1;
    end
    check("scan_sync", found, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk_1khz);
      check($sformatf("scan_sel%0d", i), dig_sel_o, exp_sel[i]);
      check($sformatf("scan_seg%0d", i), seg_o, exp_seg[i]);
    end

    // Clear beats a coincident up at 30.
    apply(0, 0, 0, 0, 1);
    pulses(30, 1, 0, 0, 0);
    check("p1_30", score_p1_o, 8'h30);
    apply(1, 0, 0, 0, 1);
    check("clear_priority", score_p1_o, 8'h00);

    // Reset mid-scan with p2_up held across release.
    pulses(3, 0, 0, 1, 0);
    check("p2_03", score_p2_o, 8'h03);
    @(negedge clk_1khz);
    p2_up_i = 1'b1;
    #2 rst_i = 1'b0;
    @(negedge clk_1khz);
    check("mid_rst_p1", score_p1_o, 8'h00);
    check("mid_rst_p2", score_p2_o, 8'h00);
    check("mid_rst_sel", dig_sel_o, 4'b0001);
    check("mid_rst_seg", seg_o, 7'h00);
    rst_i = 1'b1;
    repeat (3) @(negedge clk_1khz);
    check("held_through_release", score_p2_o, 8'h00);
    p2_up_i = 1'b0;
    @(negedge clk_1khz);
    pulses(1, 0, 0, 1, 0);
    check("p2_after_release", score_p2_o, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter MAX_SCORE, default 99, upper score limit per player, legal range 1..99.
REQ-002 SHALL have port clk_1khz  input  1  system clock, 1 kHz, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port p1_up_i  input  1  player 1 increment request (count_up of player 1 pushbutton_processor).
REQ-005 SHALL have port p1_down_i  input  1  player 1 decrement request (count_down of player 1 pushbutton_processor).
REQ-006 SHALL have port p2_up_i  input  1  player 2 increment request.
REQ-007 SHALL have port p2_down_i  input  1  player 2 decrement request.
REQ-008 SHALL have port clear_i  input  1  synchronous clear of both scores.
REQ-009 SHALL have port score_p1_o  output  8  player 1 score, BCD, [7:4] tens, [3:0] units.
REQ-010 SHALL have port score_p2_o  output  8  player 2 score, BCD.
REQ-011 SHALL have port seg_o  output  7  segment drive, active-high, bit order gfedcba.
REQ-012 SHALL have port dig_sel_o  output  4  digit select, one-hot, active-high.

Function
REQ-013 SHALL treat each request input as level-tolerant: event = input high now AND low on previous clock edge (per-input history register); a held level counts exactly once.
REQ-014 SHALL update the score register on the same rising edge that first samples the request high; new score visible on score_pX_o one cycle after request rises.
REQ-015 SHALL increment by 1 on up event; at MAX_SCORE, up event leaves score unchanged (saturate, no wrap).
REQ-016 SHALL decrement by 1 on down event; at 0, down event leaves score unchanged.
REQ-017 SHALL leave a player's score unchanged when up and down events for that player occur on the same edge.
REQ-018 SHALL process both players independently; simultaneous events for P1 and P2 both take effect on the same edge.
REQ-019 SHALL give clear_i priority over all events: scores become 0 on the edge clear_i is sampled high; edge-history registers still update normally.
REQ-020 SHALL hold scores in BCD: units 9 + 1 -> units 0, tens +1; units 0 - 1 -> units 9, tens -1.
REQ-021 SHALL run a 2-bit scan index incrementing every clock, wrapping 3 -> 0; each digit refreshed at 250 Hz.
REQ-022 SHALL map scan index 0/1/2/3 to P1 tens / P1 units / P2 tens / P2 units with dig_sel_o 0001/0010/0100/1000.
REQ-023 SHALL register seg_o and dig_sel_o so both change on the same edge (no skew between select and segments).
REQ-024 SHALL encode digits 0..9 as 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex, gfedcba).
REQ-025 SHALL blank a tens digit (seg_o = 00) when its value is 0; units digit never blanked.

Reset
REQ-026 SHALL, while rst_i low, force score_p1_o = 00, score_p2_o = 00, edge-history registers = 0, scan index = 0, dig_sel_o = 0001, seg_o = 00.
REQ-027 SHALL, if rst_i asserts mid-operation, discard any pending event; a request held high across reset release is not counted (history registers reset to 0, but input must be seen low first -- history loads the input on the first edge after release without generating an event).

Structure
REQ-028 SHALL place the 7-segment encoding table, digit-select one-hot constants and BCD digit width in a shared package scoreboard_pkg.
REQ-029 SHALL instantiate one sub-module bcd_score_counter per player (edge detect, saturating BCD up/down, clear); display scan and segment decode live in score_keeper.

Verification
REQ-030 SHALL test: reset, 12 single-cycle p1_up_i pulses -> score_p1_o = 12h, score_p2_o = 00h.
REQ-031 SHALL test: p1_up_i held high 50 cycles -> score_p1_o increments exactly once.
REQ-032 SHALL test: score_p2_o = 09h, one p2_up_i -> 10h; then one p2_down_i -> 09h; at 00h, p2_down_i -> stays 00h; at 99h, p2_up_i -> stays 99h.
REQ-033 SHALL test: p1_up_i and p1_down_i rise on same edge at score 05h -> stays 05h; same edge p2_up_i -> P2 increments.
REQ-034 SHALL test: scores 42h/07h, observe 4 consecutive cycles -> (dig_sel_o, seg_o) = (0001,66), (0010,5B), (0100,00), (1000,07).
REQ-035 SHALL test: clear_i high coincident with p1_up_i at 30h -> 00h; rst_i low mid-scan with p2_up_i held through release -> all outputs at reset values, score_p2_o stays 00h.
